// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the IF stage (master) and the
// instruction-memory responder (slave), including the IF flush.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetches, waits LATENCY cycles, returns
// the word (or NOP on a bad address); flush cancels, load port programs memory.
//
// state  | meaning
// S_IDLE | no fetch outstanding, ready for a request
// S_WAIT | fetch accepted, wait counter running
// S_RESP | response registered and presented until handoff
module imem_responder #(
  parameter int          DEPTH_LOG2 = 6,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_responder_if.slave       bus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(LATENCY);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] rd_addr;
  logic        rd_err;
  logic        accept;
  logic        load_rsp;
  logic [31:0] rsp_instr_q;
  logic [31:0] rsp_addr_q;
  logic        rsp_err_q;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign bus.req_ready = (state == S_IDLE) || ((state == S_RESP) && bus.rsp_ready) || bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the accepted address is read in the same cycle.
  assign rd_addr  = accept ? bus.req_addr : cap_addr;
  assign rd_err   = (rd_addr[1:0] != 2'b00) || (rd_addr[31:DEPTH_LOG2+2] != '0);
  assign load_rsp = (state_nxt == S_RESP) && (accept || (state != S_RESP));

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (LAT == 3'd0) ? S_RESP : S_WAIT;
    end else if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_WAIT:  if (cnt == 3'd1) state_nxt = S_RESP;
        S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      cap_addr    <= 32'd0;
      rsp_instr_q <= 32'd0;
      rsp_addr_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= LAT;
        cap_addr <= bus.req_addr;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (load_rsp) begin
        rsp_addr_q  <= rd_addr;
        rsp_err_q   <= rd_err;
        rsp_instr_q <= rd_err ? NOP : mem[rd_addr[DEPTH_LOG2+1:2]];
      end
    end
  end

  // Not reset; a same-edge write is seen by the next read, not this one.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != S_IDLE);

endmodule
